// File: rtl/tv_pkg.sv
// Shared types and vector field helpers for the test-vector sequencer.
package tv_pkg;

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  localparam int ERR_W = 16;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  // Helpers work on a fixed wide container; callers cast to the real widths.
  localparam int MAXW = 32;

  // Input field is stored MSB-first for dut_a[0], so it is bit-reversed on the way out.
  function automatic logic [MAXW-1:0] vec_inputs(input logic [MAXW-1:0] v,
                                                 input int nin,
                                                 input int nout);
    logic [MAXW-1:0] field;
    logic [MAXW-1:0] rev;
    field = v >> nout;
    rev   = {<<{field}};
    return rev >> (MAXW - nin);
  endfunction

  function automatic logic [MAXW-1:0] vec_expected(input logic [MAXW-1:0] v,
                                                   input int nout);
    return v & ~({MAXW{1'b1}} << nout);
  endfunction

endpackage

// File: rtl/tv_mem.sv
// Vector memory: synchronous write, asynchronous read, contents not reset.
module tv_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 5
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tv_sequencer.sv
// Applies stored vectors to a small combinational DUT, waits, compares and counts errors.
// Optional TV_STOP_ON_FAIL_EN: halt on the first mismatch and report fail_idx.
module tv_sequencer
  import tv_pkg::*;
#(
  parameter int NIN    = 4,
  parameter int NOUT   = 1,
  parameter int DEPTH  = 16,
  parameter int SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [NIN+NOUT-1:0]      ld_data,
  input  logic [$clog2(DEPTH):0]   num_vec,
  input  logic                     start,
  input  logic [NOUT-1:0]          dut_y,
  output logic [NIN-1:0]           dut_a,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   vectornum,
  output logic [ERR_W-1:0]         errors,
  output logic                     pass
`ifdef TV_STOP_ON_FAIL_EN
  ,output logic [$clog2(DEPTH)-1:0] fail_idx
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int W  = NIN + NOUT;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t          state, state_nxt;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   num_clamp;
  logic [SW-1:0]   settle_cnt;
  logic [NOUT-1:0] exp_q;
  logic [AW-1:0]   rd_addr;
  logic [W-1:0]    rd_data;
  logic [NIN-1:0]  vec_a;
  logic [NOUT-1:0] vec_e;
  logic            mem_we;
  logic            settled;
  logic            last_vec;
  logic            mismatch;

  assign busy      = (state == APPLY) || (state == CHECK);
  assign done      = (state == DONE);
  assign pass      = done && (errors == '0);
  assign mem_we    = ld_we && !busy;
  assign num_clamp = (num_vec > CW'(DEPTH)) ? CW'(DEPTH) : num_vec;
  assign settled   = (settle_cnt == SW'(SETTLE - 1));
  assign last_vec  = ((vectornum + CW'(1)) == count_q);
  // 4-state compare so an X or Z from the DUT is scored as a failure in simulation.
  assign mismatch  = (dut_y !== exp_q);

  // While checking, the read port already points at the next vector to apply.
  assign rd_addr = (state == CHECK) ? vectornum[AW-1:0] + AW'(1) : '0;
  assign vec_a   = NIN'(vec_inputs(MAXW'(rd_data), NIN, NOUT));
  assign vec_e   = NOUT'(vec_expected(MAXW'(rd_data), NOUT));

  tv_mem #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (num_vec == '0) ? DONE : APPLY;
      end
      APPLY: begin
        if (settled) state_nxt = CHECK;
      end
      CHECK: begin
        state_nxt = last_vec ? DONE : APPLY;
`ifdef TV_STOP_ON_FAIL_EN
        if (mismatch) state_nxt = DONE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: vector drive, settle timing, counters and the error score.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dut_a      <= '0;
      exp_q      <= '0;
      vectornum  <= '0;
      errors     <= '0;
      count_q    <= '0;
      settle_cnt <= '0;
`ifdef TV_STOP_ON_FAIL_EN
      fail_idx   <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vectornum  <= '0;
            errors     <= '0;
            count_q    <= num_clamp;
            settle_cnt <= '0;
`ifdef TV_STOP_ON_FAIL_EN
            fail_idx   <= '0;
`endif
            if (num_vec != '0) begin
              dut_a <= vec_a;
              exp_q <= vec_e;
            end
          end
        end
        APPLY: begin
          settle_cnt <= settled ? '0 : settle_cnt + SW'(1);
        end
        CHECK: begin
          vectornum <= vectornum + CW'(1);
          if (mismatch && (errors != ERR_MAX)) errors <= errors + ERR_W'(1);
`ifdef TV_STOP_ON_FAIL_EN
          if (mismatch) fail_idx <= vectornum[AW-1:0];
`endif
          if (state_nxt == APPLY) begin
            dut_a <= vec_a;
            exp_q <= vec_e;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tv_sequencer.sv
// Scoreboard bench for tv_sequencer; follows TV_STOP_ON_FAIL_EN when defined.
module tb_tv_sequencer;

  localparam int NIN    = 4;
  localparam int NOUT   = 1;
  localparam int DEPTH  = 16;
  localparam int SETTLE = 2;

  logic        clk     = 1'b0;
  logic        reset   = 1'b0;
  logic        ld_we   = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [4:0]  ld_data = '0;
  logic [4:0]  num_vec = '0;
  logic        start   = 1'b0;
  logic [0:0]  dut_y;
  logic [3:0]  dut_a;
  logic        busy;
  logic        done;
  logic [4:0]  vectornum;
  logic [15:0] errors;
  logic        pass;
`ifdef TV_STOP_ON_FAIL_EN
  logic [3:0]  fail_idx;
`endif

  typedef struct {
    int vn;
    int errs;
    int pass;
    int lat;
    int a;
    int fidx;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [4:0] mem_m [DEPTH];
  int         model_a    = 0;
  int         total      = 0;
  int         bad        = 0;
  int         cyc        = 0;
  int         start_cyc  = 0;
  logic       start_real = 1'b0;
  logic       prev_done  = 1'b0;

  // Exercise circuit standing in for the device under test.
  function automatic logic circuit(input logic [3:0] a);
    return (a[0] & a[1]) | (a[2] ^ a[3]);
  endfunction

  assign dut_y = circuit(dut_a);

  tv_sequencer #(
    .NIN    (NIN),
    .NOUT   (NOUT),
    .DEPTH  (DEPTH),
    .SETTLE (SETTLE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .num_vec   (num_vec),
    .start     (start),
    .dut_y     (dut_y),
    .dut_a     (dut_a),
    .busy      (busy),
    .done      (done),
    .vectornum (vectornum),
    .errors    (errors),
    .pass      (pass)
`ifdef TV_STOP_ON_FAIL_EN
    ,.fail_idx (fail_idx)
`endif
  );

  always #5 clk = ~clk;

  // Input field bit (3-k) of a stored entry drives dut_a[k].
  function automatic int inputsOf(input int entry);
    int field = (entry >> 1) & 15;
    int a = 0;
    for (int k = 0; k < 4; k++)
      if (((field >> (3 - k)) & 1) != 0) a += (1 << k);
    return a;
  endfunction

  function automatic int entryFor(input int a, input int flip);
    int field = 0;
    for (int k = 0; k < 4; k++)
      if (((a >> k) & 1) != 0) field += (1 << (3 - k));
    return (field << 1) | (int'(circuit(4'(a))) ^ flip);
  endfunction

  function automatic exp_t modelRun(input int n);
    exp_t r;
    int m = (n > DEPTH) ? DEPTH : n;
    r.vn = 0; r.errs = 0; r.fidx = 0; r.a = model_a;
    for (int i = 0; i < m; i++) begin
      r.a = inputsOf(int'(mem_m[i]));
      r.vn++;
      if (int'(circuit(4'(r.a))) != int'(mem_m[i][0])) begin
        r.errs++;
`ifdef TV_STOP_ON_FAIL_EN
        r.fidx = i;
        break;
`endif
      end
    end
    r.pass = (r.errs == 0) ? 1 : 0;
    r.lat  = r.vn * (SETTLE + 1) + 1;
    return r;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (start && start_real) start_cyc = cyc;
    cyc = cyc + 1;
  end

  // Monitor: each rising done retires one scoreboard entry.
  always @(negedge clk) begin
    if (done && !prev_done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("vectornum", longint'(vectornum), longint'(mon_e.vn));
        checkOutput("errors", longint'(errors), longint'(mon_e.errs));
        checkOutput("pass", longint'(pass), longint'(mon_e.pass));
        checkOutput("latency", longint'(cyc - start_cyc), longint'(mon_e.lat));
        checkOutput("dut_a_hold", longint'(dut_a), longint'(mon_e.a));
        checkOutput("busy_at_done", longint'(busy), 0);
`ifdef TV_STOP_ON_FAIL_EN
        checkOutput("fail_idx", longint'(fail_idx), longint'(mon_e.fidx));
`endif
      end
    end
    prev_done = done;
  end

  task automatic loadEntry(input int addr, input int a, input int flip);
    @(negedge clk);
    ld_we   = 1'b1;
    ld_addr = 4'(addr);
    ld_data = 5'(entryFor(a, flip));
    mem_m[addr] = 5'(entryFor(a, flip));
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic loadSet(input int fa, input int fb);
    for (int i = 0; i < DEPTH; i++)
      loadEntry(i, i, (i == fa || i == fb) ? 1 : 0);
  endtask

  task automatic loadRandom();
    for (int i = 0; i < DEPTH; i++)
      loadEntry(i, int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0) ? 1 : 0);
  endtask

  task automatic applyStimulus(input int n, input bit expect_done);
    exp_t e;
    if (expect_done) begin
      e = modelRun(n);
      sb.push_back(e);
      model_a = e.a;
    end
    @(negedge clk);
    start      = 1'b1;
    start_real = 1'b1;
    num_vec    = 5'(n);
    @(negedge clk);
    start      = 1'b0;
    start_real = 1'b0;
  endtask

  task automatic waitResult();
    int k = 0;
    while (sb.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      checkOutput("done_timeout", longint'(sb.size()), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_dut_a"}, longint'(dut_a), 0);
    checkOutput({tag, "_busy"}, longint'(busy), 0);
    checkOutput({tag, "_done"}, longint'(done), 0);
    checkOutput({tag, "_pass"}, longint'(pass), 0);
    checkOutput({tag, "_vectornum"}, longint'(vectornum), 0);
    checkOutput({tag, "_errors"}, longint'(errors), 0);
  endtask

  initial begin
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    checkIdleOutputs("reset");
    reset = 1'b0;

    // Empty run straight from IDLE; busy must stay low.
    applyStimulus(0, 1);
    checkOutput("busy_empty_run", longint'(busy), 0);
    waitResult();

    loadSet(-1, -1);
    applyStimulus(16, 1);
    waitResult();

    loadSet(3, 9);
    applyStimulus(16, 1);
    waitResult();

    loadSet(6, -1);
    applyStimulus(16, 1);
    waitResult();

    // Abort during APPLY of vector 5, then rerun a short set from intact memory.
    loadSet(-1, -1);
    applyStimulus(16, 0);
    repeat (15) @(negedge clk);
    checkOutput("abort_vectornum", longint'(vectornum), 5);
    checkOutput("abort_busy", longint'(busy), 1);
    checkOutput("abort_dut_a", longint'(dut_a), longint'(inputsOf(int'(mem_m[5]))));
    reset = 1'b1;
    #1;
    checkIdleOutputs("abort");
    @(negedge clk);
    reset   = 1'b0;
    model_a = 0;
    applyStimulus(4, 1);
    waitResult();

    // start and ld_we pulsed mid-run must not disturb anything.
    loadSet(-1, -1);
    applyStimulus(16, 1);
    repeat (4) @(negedge clk);
    start   = 1'b1;
    num_vec = 5'd2;
    ld_we   = 1'b1;
    ld_addr = 4'd15;
    ld_data = mem_m[15] ^ 5'd1;
    @(negedge clk);
    ld_addr = 4'd10;
    ld_data = mem_m[10] ^ 5'd1;
    @(negedge clk);
    start = 1'b0;
    ld_we = 1'b0;
    waitResult();
    applyStimulus(16, 1);
    waitResult();

    applyStimulus(25, 1);
    waitResult();

    for (int r = 0; r < 8; r++) begin
      loadRandom();
      applyStimulus(int'($urandom_range(1, 20)), 1);
      waitResult();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tv_sequencer.md
Name: tv_sequencer

Overview:
- Synthesizable hardware test-vector sequencer that sits directly upstream of a small combinational DUT (4-input, 1-output exercise circuits).
- Holds a loadable vector memory and applies each vector's input field to the DUT.
- Waits a programmable settle time, then compares the DUT output with the expected field.
- Counts vectors and errors, and flags completion; it is the on-chip equivalent of the bench's readmemb/apply/check loop.

Parameters:
- NIN, 4, DUT input width
- NOUT, 1, DUT output width
- DEPTH, 16, vector memory entries (power of 2)
- SETTLE, 2, cycles dut_a is held before sampling dut_y (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- ld_we  in  1  vector memory write enable
- ld_addr  in  log2(DEPTH)  write address
- ld_data  in  NIN+NOUT  vector {inputs, expected}; input field MSB drives dut_a[0], input field LSB drives dut_a[NIN-1]; low NOUT bits are expected
- num_vec  in  log2(DEPTH)+1  number of vectors to run, sampled on start
- start  in  1  one-cycle run request
- dut_y  in  NOUT  DUT output
- dut_a  out  NIN  DUT input drive
- busy  out  1  run in progress
- done  out  1  run finished, held until next start or reset
- vectornum  out  log2(DEPTH)+1  vectors completed
- errors  out  16  mismatch count, saturating at 16'hFFFF
- pass  out  1  done && errors==0

Behaviour:
- Reset values (async assert): state IDLE; dut_a=0; busy=0; done=0; pass=0; vectornum=0; errors=0; settle counter=0. Vector memory is not reset.
- FSM states and transitions:
  - IDLE: start && num_vec!=0 → APPLY; clears vectornum, errors, done; latches num_vec.
  - IDLE: start && num_vec==0 → DONE directly; counts 0, pass=1.
  - APPLY: dut_a registered from mem[vectornum] on entry; settle counter counts SETTLE cycles → CHECK.
  - CHECK: one cycle; compare dut_y against expected with 4-state mismatch (X/Z on dut_y counts as error in simulation); errors+=mismatch; vectornum+=1. If vectornum+1==latched count → DONE, else → APPLY (next vector).
  - DONE: done=1, busy=0. start → behaves as from IDLE (restart with new num_vec).
- busy=1 in APPLY and CHECK only.
- Per-vector latency: SETTLE+1 cycles. Total run: num_vec*(SETTLE+1)+1 cycles from start to done.
- start while busy is ignored.
- ld_we while busy is ignored (memory content frozen during a run). ld_we in IDLE/DONE writes on the clock edge.
- num_vec > DEPTH is clamped to DEPTH.
- dut_a holds the last applied vector in DONE.
- errors saturates; it never wraps.
- Reset mid-run aborts immediately to IDLE with all outputs at reset values.

Optional Feature:
- Macro TV_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK transitions to DONE. vectornum includes the failing vector, errors=1, and an extra output fail_idx (log2(DEPTH) bits) holds the failing index; fail_idx resets to 0.
- Undefined: the run always completes all vectors; no fail_idx port.

Decomposition:
- Package tv_pkg holds:
  - state enum typedef (IDLE, APPLY, CHECK, DONE)
  - ERR_W=16 and ERR_MAX constants
  - vector field-slicing helper functions for the input and expected fields
- One natural sub-module, tv_mem: DEPTH x (NIN+NOUT) register array, synchronous write, asynchronous read.
- FSM, counters and compare stay in the top.

Test Plan:
- Load 16 vectors of a correct 4-input function (DUT model matches), num_vec=16, SETTLE=2, start → done after 49 cycles; vectornum=16, errors=0, pass=1.
- Same load with expected bits of vectors 3 and 9 inverted → errors=2, pass=0, vectornum=16.
- num_vec=0, start → DONE next cycle; busy never asserts, pass=1.
- Reset asserted during APPLY of vector 5 → outputs immediately 0, state IDLE. Subsequent start with num_vec=4 → done, vectornum=4, memory contents intact.
- During a run, pulse start and ld_we with ld_data changes → no restart, no memory change; results equal an undisturbed run.
- With TV_STOP_ON_FAIL_EN defined, mismatch at vector 6 → done, vectornum=7, errors=1, fail_idx=6.
